// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product sequencer: default operand and
// accumulator widths plus the sequencer state encoding.
package mac_pkg;

    localparam int unsigned A_WIDTH_DEF   = 16;
    localparam int unsigned B_WIDTH_DEF   = 16;
    localparam int unsigned ACC_WIDTH_DEF = A_WIDTH_DEF + B_WIDTH_DEF;
    localparam int unsigned LEN_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : mac_pkg

// File: rtl/mac_dot_sequencer_mac.sv
// MAC_UNIT: combinational unsigned multiply-accumulate.
// Output = a * b + Addend, full-width product, sum wraps at ACC_WIDTH bits.
module MAC_UNIT #(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic [ACC_WIDTH-1:0] Addend,
    output logic [ACC_WIDTH-1:0] Output
);

    logic [A_WIDTH+B_WIDTH-1:0] prod;

    // Zero-extend both operands so the product is computed at full width.
    always_comb begin
        prod   = {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};
        Output = ACC_WIDTH'(prod) + Addend;
    end

endmodule : MAC_UNIT

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: runs a dot product through one shared MAC_UNIT.
// Accepts a job (len, bias), streams len operand pairs, returns
// bias + sum(a_i * b_i) mod 2^ACC_WIDTH over a valid/ready result port.
// Optional feature: define MAC_DOT_OVF_EN to add the sticky `ovf` wrap flag.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned A_WIDTH   = A_WIDTH_DEF,
    parameter int unsigned B_WIDTH   = B_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH = A_WIDTH + B_WIDTH,
    parameter int unsigned LEN_W     = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [ACC_WIDTH-1:0] bias,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_result
`ifdef MAC_DOT_OVF_EN
    ,
    output logic                 ovf
`endif
);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [ACC_WIDTH-1:0] mac_out;
    logic                 in_hs;

    // The accumulator register is the MAC addend every cycle.
    MAC_UNIT #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .a      (in_a),
        .b      (in_b),
        .Addend (acc_q),
        .Output (mac_out)
    );

    // Handshake-visible outputs decode directly from the state register.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        in_ready   = (state_q == ST_RUN);
        out_valid  = (state_q == ST_DONE);
        out_result = acc_q;
        in_hs      = in_valid && (state_q == ST_RUN);
    end

    // Next-state, accumulator and remaining-count logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = bias;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (in_hs) begin
                    acc_d = mac_out;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, accumulator and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

`ifdef MAC_DOT_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky wrap flag: product < 2^ACC_WIDTH, so a wrap shows as the
    // new sum falling below the old one whenever the product is nonzero.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_IDLE && start) begin
            ovf_d = 1'b0;
        end else if (in_hs && (in_a != '0) && (in_b != '0) && (mac_out < acc_q)) begin
            ovf_d = 1'b1;
        end
    end

    // Wrap flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule : mac_dot_sequencer

// File: tb/tb_mac_dot_sequencer.sv
// Testbench for mac_dot_sequencer: directed jobs, expected results pushed
// into a scoreboard queue and checked by an independent result monitor.
module tb_mac_dot_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 16;
    localparam int unsigned CW = 32;
    localparam int unsigned LW = 8;

    typedef struct {
        logic [CW-1:0] res;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [CW-1:0] bias = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_result;
`ifdef MAC_DOT_OVF_EN
    logic          ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mac_dot_sequencer #(
        .A_WIDTH   (AW),
        .B_WIDTH   (BW),
        .ACC_WIDTH (CW),
        .LEN_W     (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .bias       (bias),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef MAC_DOT_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every accepted result against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", out_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", {32'h0, out_result}, {32'h0, e.res});
`ifdef MAC_DOT_OVF_EN
                check("ovf", {63'h0, ovf}, {63'h0, e.ovf});
`endif
            end
        end
    end

    task automatic push_exp(input logic [CW-1:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Pulse start for one cycle; returns at posedge+1 after it was sampled.
    task automatic do_start(input logic [LW-1:0] l, input logic [CW-1:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one pair after some bubble cycles; returns at posedge+1 after the handshake.
    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input int bubbles);
        int n;
        for (int i = 0; i < bubbles; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        if (n == 50) check("in_ready_timeout", 64'h0, 64'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
    endtask

    // Wait (bounded) for the result handshake; returns at posedge+1 after it.
    task automatic wait_result();
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid && out_ready) break;
            n++;
        end
        if (n == 100) check("result_timeout", 64'h0, 64'h1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      {63'h0, busy},       64'h0);
        check({tag, "_in_ready"},  {63'h0, in_ready},   64'h0);
        check({tag, "_out_valid"}, {63'h0, out_valid},  64'h0);
        check({tag, "_out_result"},{32'h0, out_result}, 64'h0);
`ifdef MAC_DOT_OVF_EN
        check({tag, "_ovf"},       {63'h0, ovf},        64'h0);
`endif
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Job 1: 10 + 2*3 + 4*5 + 6*7 = 78, back-to-back pairs.
        push_exp(32'd78, 1'b0);
        do_start(8'd3, 32'd10);
        check("start_to_in_ready", {63'h0, in_ready}, 64'h1);
        send(16'd2, 16'd3, 0);
        send(16'd4, 16'd5, 0);
        send(16'd6, 16'd7, 0);
        check("last_to_out_valid", {63'h0, out_valid}, 64'h1);
        wait_result();
        check("job1_idle", {63'h0, busy}, 64'h0);

        // Job 2: len 0 returns bias the cycle after start.
        push_exp(32'h1234, 1'b0);
        do_start(8'd0, 32'h1234);
        check("len0_in_ready", {63'h0, in_ready}, 64'h0);
        check("len0_out_valid", {63'h0, out_valid}, 64'h1);
        check("len0_out_result", {32'h0, out_result}, 64'h1234);
        wait_result();

        // Job 3: 2 * 0xFFFE0001 = 0x1FFFC0002 wraps to 0xFFFC0002.
        push_exp(32'hFFFC0002, 1'b1);
        do_start(8'd2, 32'd0);
        send(16'hFFFF, 16'hFFFF, 0);
        send(16'hFFFF, 16'hFFFF, 0);
        wait_result();

        // Job 4: 1+4+9+16 = 30 with bubbles, back-pressure and a stray start.
        out_ready = 1'b0;
        push_exp(32'd30, 1'b0);
        do_start(8'd4, 32'd0);
        send(16'd1, 16'd1, 1);
        send(16'd2, 16'd2, 2);
        send(16'd3, 16'd3, 0);
        send(16'd4, 16'd4, 3);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd1;
            bias  = 32'd99;
            @(negedge clk);
            check("hold_out_valid", {63'h0, out_valid}, 64'h1);
            check("hold_out_result", {32'h0, out_result}, 64'd30);
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_result();
        check("job4_idle", {63'h0, busy}, 64'h0);
        @(posedge clk); #1;
        check("stray_start_ignored", {63'h0, busy}, 64'h0);

        // Job 5: reset after two handshakes discards the partial sum.
        do_start(8'd5, 32'd123);
        send(16'd1, 16'd2, 0);
        send(16'd3, 16'd4, 0);
        rst = 1'b1;
        #1 check_reset_outputs("midjob_reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Job 6: 7 + 3*3 = 16.
        push_exp(32'd16, 1'b0);
        do_start(8'd1, 32'd7);
        send(16'd3, 16'd3, 0);
        check("job6_out_valid", {63'h0, out_valid}, 64'h1);
        wait_result();

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mac_dot_sequencer

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Sequencer that runs a dot product through one shared `MAC_UNIT` (A_WIDTH x B_WIDTH multiply plus ACC_WIDTH addend, combinational). It accepts a job command (length and bias), streams operand pairs over a valid/ready port, and feeds the registered accumulator back as the MAC addend every cycle. It returns the final sum over a valid/ready result port. The block sits between the operand-fetch logic and the result consumer; it is the only owner of the MAC instance.

## Interface
- `A_WIDTH`, 16, width of operand a
- `B_WIDTH`, 16, width of operand b
- `ACC_WIDTH`, A_WIDTH+B_WIDTH, accumulator/result width; must equal the MAC output width
- `LEN_W`, 8, width of the job length field
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  job request, sampled only in IDLE
- `len`  in  LEN_W  number of operand pairs, captured with start
- `bias`  in  ACC_WIDTH  initial accumulator value, captured with start
- `busy`  out  1  high in RUN and DONE
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  high only in RUN
- `in_a`  in  A_WIDTH  operand a, unsigned
- `in_b`  in  B_WIDTH  operand b, unsigned
- `out_valid`  out  1  result valid, high only in DONE
- `out_ready`  in  1  consumer accepts result
- `out_result`  out  ACC_WIDTH  bias + sum of a_i*b_i, modulo 2^ACC_WIDTH
- `ovf`  out  1  sticky wrap flag; present only with MAC_DOT_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE and start=1 with len!=0: acc<=bias, remaining<=len, next state RUN.
- IDLE and start=1 with len==0: acc<=bias, next state DONE.
- RUN: in_ready=1. On each in_valid&&in_ready: acc<=MAC(in_a, in_b, acc), remaining<=remaining-1.
- RUN exits to DONE on the handshake where remaining==1.
- DONE: out_valid=1 and out_result=acc, held stable until out_valid&&out_ready, then next state IDLE.
- start is ignored outside IDLE; no queuing of commands.
- Arithmetic is unsigned. The product is a full A_WIDTH+B_WIDTH bits, the sum wraps modulo 2^ACC_WIDTH, and no sign extension is done.
- out_result is driven from the acc register only, never from the combinational MAC output.
- in_a/in_b values are don't-care when no handshake occurs; acc does not change on bubbles.

## Timing
- Reset values: state=IDLE, acc=0, remaining=0, busy=0, in_ready=0, out_valid=0, out_result=0, ovf=0.
- start to in_ready: 1 cycle (in_ready rises the cycle after start is sampled).
- Throughput: one pair per cycle when in_valid is held high.
- Last input handshake to out_valid: 1 cycle.
- len==0: out_valid high 1 cycle after start, out_result=bias.
- Minimum job turnaround: start accepted again the cycle after the result handshake; no same-cycle result-out/start-in overlap.
- Reset asserted mid-job: all state returns to reset values immediately; the partial sum is discarded and no result is produced.
- out_ready held low: DONE persists indefinitely with out_result stable.

## Configuration
- `MAC_DOT_OVF_EN` defined: `ovf` port exists.
  - ovf is cleared when a job starts.
  - ovf is set on any accumulate where the true sum is at least 2^ACC_WIDTH (detected as new acc < old acc when the product is nonzero).
  - ovf holds until the next start or reset and is valid alongside out_valid.
- `MAC_DOT_OVF_EN` undefined: no `ovf` port and no detection logic; results still wrap silently.

## Structure
- Shared package `mac_pkg`:
  - default A_WIDTH/B_WIDTH/ACC_WIDTH constants
  - state enum (IDLE, RUN, DONE)
- One sub-module: the existing `MAC_UNIT`, instantiated once with port order (a, b, Addend, Output). Addend is tied to acc.
- FSM, counter and accumulator stay in this module.

## Test plan
- len=3, bias=10, pairs (2,3),(4,5),(6,7) back-to-back -> out_result=78, out_valid 1 cycle after third handshake, ovf=0.
- len=0, bias=0x1234 -> out_valid the cycle after start, out_result=0x1234, in_ready never high.
- len=2, bias=0, pairs (0xFFFF,0xFFFF) x2 -> out_result=0xFFFC0002; ovf=1 with MAC_DOT_OVF_EN.
- len=4, bias=0, pairs (1,1)..(4,4) with in_valid bubbles, plus out_ready low for 5 cycles and start pulsed during DONE -> out_result=30 held stable, extra start ignored, IDLE after handshake.
- len=5, reset asserted after 2 handshakes -> all outputs at reset values. A following job with len=1, bias=7, pair (3,3) -> out_result=16.
